// File: rtl/ctrl_encode_def.sv
`default_nettype none
// ============================================================================
// Package     : ctrl_encode_def
// Description : Shared ALU operation encoding for the execute stage, plus
//               small classification helpers used by the ALU and its
//               iterative mul/div datapath.
// Revision    : 1.0  initial release
// ============================================================================
package ctrl_encode_def;

  localparam int ALUOP_W = 5;
  typedef logic [ALUOP_W-1:0] aluop_t;

  // Code 0 is deliberately left as a no-op; any code not listed below
  // returns operand A.
  localparam aluop_t ALUOp_nop    = 5'd0;
  localparam aluop_t ALUOp_lui    = 5'd1;
  localparam aluop_t ALUOp_add    = 5'd2;
  localparam aluop_t ALUOp_sub    = 5'd3;
  localparam aluop_t ALUOp_xor    = 5'd4;
  localparam aluop_t ALUOp_or     = 5'd5;
  localparam aluop_t ALUOp_and    = 5'd6;
  localparam aluop_t ALUOp_sll    = 5'd7;
  localparam aluop_t ALUOp_srl    = 5'd8;
  localparam aluop_t ALUOp_sra    = 5'd9;
  localparam aluop_t ALUOp_slt    = 5'd10;
  localparam aluop_t ALUOp_sltu   = 5'd11;
  localparam aluop_t ALUOp_beq    = 5'd12;
  localparam aluop_t ALUOp_bne    = 5'd13;
  localparam aluop_t ALUOp_blt    = 5'd14;
  localparam aluop_t ALUOp_bge    = 5'd15;
  localparam aluop_t ALUOp_bltu   = 5'd16;
  localparam aluop_t ALUOp_bgeu   = 5'd17;
  localparam aluop_t ALUOp_mul    = 5'd18;
  localparam aluop_t ALUOp_mulh   = 5'd19;
  localparam aluop_t ALUOp_mulhsu = 5'd20;
  localparam aluop_t ALUOp_mulhu  = 5'd21;
  localparam aluop_t ALUOp_div    = 5'd22;
  localparam aluop_t ALUOp_divu   = 5'd23;
  localparam aluop_t ALUOp_rem    = 5'd24;
  localparam aluop_t ALUOp_remu   = 5'd25;

  function automatic logic is_mul(input aluop_t op);
    return op inside {ALUOp_mul, ALUOp_mulh, ALUOp_mulhsu, ALUOp_mulhu};
  endfunction

  function automatic logic is_div(input aluop_t op);
    return op inside {ALUOp_div, ALUOp_divu, ALUOp_rem, ALUOp_remu};
  endfunction

  function automatic logic is_muldiv(input aluop_t op);
    return is_mul(op) | is_div(op);
  endfunction

  function automatic logic is_branch(input aluop_t op);
    return op inside {ALUOp_beq, ALUOp_bne, ALUOp_blt, ALUOp_bge, ALUOp_bltu, ALUOp_bgeu};
  endfunction

  // Multiply variants returning the upper half of the product.
  function automatic logic is_mul_hi(input aluop_t op);
    return op inside {ALUOp_mulh, ALUOp_mulhsu, ALUOp_mulhu};
  endfunction

  function automatic logic is_mul_sa(input aluop_t op);
    return op inside {ALUOp_mulh, ALUOp_mulhsu};
  endfunction

  function automatic logic is_mul_sb(input aluop_t op);
    return op == ALUOp_mulh;
  endfunction

  function automatic logic is_div_signed(input aluop_t op);
    return op inside {ALUOp_div, ALUOp_rem};
  endfunction

  function automatic logic is_rem(input aluop_t op);
    return op inside {ALUOp_rem, ALUOp_remu};
  endfunction

endpackage : ctrl_encode_def
`default_nettype wire

// File: rtl/alu_mc_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc_iter
// Description : One-bit-per-cycle datapath for mul*/div*/rem* operations.
//               Multiply is shift-add on magnitudes, divide is restoring
//               division on magnitudes; signs are applied on the way out.
// Ports       : clk, rstn        clock, async active-low reset
//               start_i          load operands (operation accepted)
//               step_i           perform one iteration this cycle
//               op_i, a_i, b_i   operation and operands, sampled on start_i
//               done_o           this step is the last one
//               result_o         final result, valid together with done_o
// Revision    : 1.0  initial release
// ============================================================================
module alu_mc_iter
  import ctrl_encode_def::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic             step_i,
  input  aluop_t           op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;   // product accumulator / partial remainder
  logic [2*WIDTH-1:0] opa_q, opa_d;   // shifting multiplicand / divisor
  logic [WIDTH-1:0]   opb_q, opb_d;   // multiplier / dividend-then-quotient
  logic               div_q, div_d;
  logic               hi_q, hi_d;     // mul: return upper half; div: return remainder
  logic               neg_q, neg_d;   // negate the magnitude result at the end

  // Operand preparation at start. MIN negates to itself, which is still the
  // correct unsigned magnitude.
  logic             st_div, sa, sb, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    st_div = is_div(op_i);
    sa     = st_div ? is_div_signed(op_i) : is_mul_sa(op_i);
    sb     = st_div ? is_div_signed(op_i) : is_mul_sb(op_i);
    a_neg  = sa & a_i[WIDTH-1];
    b_neg  = sb & b_i[WIDTH-1];
    mag_a  = a_neg ? -a_i : a_i;
    mag_b  = b_neg ? -b_i : b_i;
  end

  // One iteration of each algorithm, evaluated from the current registers.
  logic [2*WIDTH-1:0] mul_acc, prod_s;
  logic [WIDTH:0]     rem_sh, rem_nx;
  logic [WIDTH-1:0]   quo_nx, div_val, mul_res, div_res;
  logic               rem_ge;

  always_comb begin
    mul_acc = acc_q + (opb_q[0] ? opa_q : '0);
    rem_sh  = {acc_q[WIDTH-1:0], opb_q[WIDTH-1]};
    rem_ge  = rem_sh >= {1'b0, opa_q[WIDTH-1:0]};
    rem_nx  = rem_ge ? (rem_sh - {1'b0, opa_q[WIDTH-1:0]}) : rem_sh;
    quo_nx  = {opb_q[WIDTH-2:0], rem_ge};
    // The result is taken from this cycle's step so that it can be captured
    // on the same edge that ends the final iteration.
    prod_s  = neg_q ? -mul_acc : mul_acc;
    mul_res = hi_q ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0];
    div_val = hi_q ? rem_nx[WIDTH-1:0] : quo_nx;
    div_res = neg_q ? -div_val : div_val;
  end

  assign result_o = div_q ? div_res : mul_res;
  assign done_o   = step_i && (cnt_q == SHW'(WIDTH - 1));

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    opa_d = opa_q;
    opb_d = opb_q;
    div_d = div_q;
    hi_d  = hi_q;
    neg_d = neg_q;
    if (start_i) begin
      cnt_d = '0;
      acc_d = '0;
      // Multiplicand and divisor share a register, as do multiplier and
      // dividend; multiplication is commutative so B*A is used.
      opa_d = {{WIDTH{1'b0}}, mag_b};
      opb_d = mag_a;
      div_d = st_div;
      hi_d  = st_div ? is_rem(op_i) : is_mul_hi(op_i);
      // Remainder follows the dividend's sign; everything else the XOR.
      neg_d = (st_div && is_rem(op_i)) ? a_neg : (a_neg ^ b_neg);
    end else if (step_i) begin
      cnt_d = cnt_q + SHW'(1);
      if (div_q) begin
        acc_d = {{(WIDTH-1){1'b0}}, rem_nx};
        opb_d = quo_nx;
      end else begin
        acc_d = mul_acc;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      acc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
      hi_q  <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      div_q <= div_d;
      hi_q  <= hi_d;
      neg_q <= neg_d;
    end
  end

endmodule : alu_mc_iter
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc
// Description : Multi-cycle execute-stage ALU. Single-cycle RV32I ops and
//               branch compares finish in one cycle; mul/div iterate in
//               alu_mc_iter. Valid/ready on input and output, kill flushes.
// Config      : ALU_MC_FAST_MUL_EN - when defined, mul* ops use a single
//               combinational multiply with 1-cycle latency.
// Ports       : clk, rstn            clock, async active-low reset
//               in_valid/in_ready    operation handshake
//               in_op, in_a, in_b    ALUOp and operands
//               in_tag / out_tag     passthrough tag
//               kill                 abandon the in-flight operation
//               out_valid/out_ready  result handshake
//               out_result, out_zero, out_taken   registered result flags
//               busy                 iterative operation in progress
// Revision    : 1.0  initial release
// ============================================================================
module alu_mc
  import ctrl_encode_def::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  aluop_t           in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_taken,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, taken_q, taken_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             accept, go_iter, iter_start, iter_done;
  logic [WIDTH-1:0] iter_result;

  assign in_ready = !kill && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  // Division corner cases resolve immediately and never enter BUSY.
  logic b_zero, div_ovf;
  assign b_zero  = (in_b == '0);
  assign div_ovf = is_div_signed(in_op) && (in_a == MIN_VAL) && (in_b == '1);

`ifdef ALU_MC_FAST_MUL_EN
  // Sign- or zero-extend each operand by one bit so a single signed multiply
  // covers mul/mulh/mulhsu/mulhu; only the low 2*WIDTH bits are needed.
  logic signed [WIDTH:0]     fm_a, fm_b;
  logic signed [2*WIDTH-1:0] fm_ax, fm_bx, fm_p;
  always_comb begin
    fm_a  = {is_mul_sa(in_op) & in_a[WIDTH-1], in_a};
    fm_b  = {is_mul_sb(in_op) & in_b[WIDTH-1], in_b};
    fm_ax = (2*WIDTH)'(fm_a);
    fm_bx = (2*WIDTH)'(fm_b);
    fm_p  = fm_ax * fm_bx;
  end
  assign go_iter = is_div(in_op) && !b_zero && !div_ovf;
`else
  assign go_iter = (is_div(in_op) && !b_zero && !div_ovf) || is_mul(in_op);
`endif

  // Single-cycle results (including the resolved division corner cases).
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_taken, br_cond;

  assign shamt = in_b[SHW-1:0];

  always_comb begin
    br_cond = 1'b0;
    case (in_op)
      ALUOp_beq:  br_cond = (in_a == in_b);
      ALUOp_bne:  br_cond = (in_a != in_b);
      ALUOp_blt:  br_cond = ($signed(in_a) <  $signed(in_b));
      ALUOp_bge:  br_cond = ($signed(in_a) >= $signed(in_b));
      ALUOp_bltu: br_cond = (in_a <  in_b);
      ALUOp_bgeu: br_cond = (in_a >= in_b);
      default:    br_cond = 1'b0;
    endcase
  end

  always_comb begin
    sc_res   = in_a;
    sc_taken = 1'b0;
    case (in_op)
      ALUOp_lui:  sc_res = in_b;
      ALUOp_add:  sc_res = in_a + in_b;
      ALUOp_sub:  sc_res = in_a - in_b;
      ALUOp_xor:  sc_res = in_a ^ in_b;
      ALUOp_or:   sc_res = in_a | in_b;
      ALUOp_and:  sc_res = in_a & in_b;
      ALUOp_sll:  sc_res = in_a << shamt;
      ALUOp_srl:  sc_res = in_a >> shamt;
      ALUOp_sra:  sc_res = $signed(in_a) >>> shamt;
      ALUOp_slt: begin
        sc_res    = '0;
        sc_res[0] = $signed(in_a) < $signed(in_b);
      end
      ALUOp_sltu: begin
        sc_res    = '0;
        sc_res[0] = in_a < in_b;
      end
      ALUOp_beq, ALUOp_bne, ALUOp_blt, ALUOp_bge, ALUOp_bltu, ALUOp_bgeu: begin
        sc_res    = '0;
        sc_res[0] = !br_cond;
        sc_taken  = br_cond;
      end
      ALUOp_div, ALUOp_divu, ALUOp_rem, ALUOp_remu: begin
        if (b_zero)
          sc_res = is_rem(in_op) ? in_a : '1;
        else
          sc_res = is_rem(in_op) ? '0 : MIN_VAL;
      end
`ifdef ALU_MC_FAST_MUL_EN
      ALUOp_mul, ALUOp_mulh, ALUOp_mulhsu, ALUOp_mulhu:
        sc_res = is_mul_hi(in_op) ? fm_p[2*WIDTH-1:WIDTH] : fm_p[WIDTH-1:0];
`endif
      default: sc_res = in_a;
    endcase
  end

  // Next state and result register loads. kill overrides everything.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    taken_d    = taken_q;
    tag_d      = tag_q;
    iter_start = 1'b0;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_BUSY: begin
          if (iter_done) begin
            state_d  = S_DONE;
            result_d = iter_result;
            taken_d  = 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: ;
      endcase
      // accept only happens from IDLE or a draining DONE, so it never
      // collides with the BUSY completion above.
      if (accept) begin
        tag_d = in_tag;
        if (go_iter) begin
          state_d    = S_BUSY;
          iter_start = 1'b1;
        end else begin
          state_d  = S_DONE;
          result_d = sc_res;
          taken_d  = sc_taken;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      taken_q  <= 1'b0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= (result_d == '0);
      taken_q  <= taken_d;
      tag_q    <= tag_d;
    end
  end

  alu_mc_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk      (clk),
    .rstn     (rstn),
    .start_i  (iter_start),
    .step_i   (state_q == S_BUSY),
    .op_i     (in_op),
    .a_i      (in_a),
    .b_i      (in_b),
    .done_o   (iter_done),
    .result_o (iter_result)
  );

  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q == S_BUSY);
  assign out_result = result_q;
  assign out_zero   = zero_q;
  assign out_taken  = taken_q;
  assign out_tag    = tag_q;

endmodule : alu_mc
`default_nettype wire
